// File: rtl/acc_isa_pkg.sv
// Instruction-set constants and the decoded-control bundle.
// Shared by the accumulator control block and its ALU.
package acc_isa_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_NAND = 3'b010,
    OP_LI   = 3'b011,
    OP_LA   = 3'b100,
    OP_LW   = 3'b101,
    OP_SW   = 3'b110,
    OP_BNZ  = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_SUB  = 2'b01,
    ALU_NAND = 2'b10,
    ALU_LINK = 2'b11
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    reg_we;
    logic    mem_we;
    logic    lw_sel;
    logic    acc_we;
    logic    acc_src_imm;
    logic    mem_addr_acc;
    logic    branch;
    logic    alu_src_reg;
  } ctrl_t;

endpackage

// File: rtl/acc_alu_control_if.sv
// Instruction/operand inputs and decoded-control/datapath outputs of the
// accumulator control block, grouped as one bus.
interface acc_alu_control_if #(
  parameter int DATA_W = 8,
  parameter int IMM_W  = 5
);
  logic [2:0]        opcode;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] reg_data;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] acc_out;
  logic              acc_nz;
  logic [DATA_W-1:0] alu_out;
  logic [1:0]        alu_op;
  logic              reg_we;
  logic              mem_we;
  logic              lw_sel;
  logic              acc_we;
  logic              acc_src_imm;
  logic              mem_addr_acc;
  logic              branch;
  logic              branch_taken;
  logic              alu_src_reg;

  modport master (
    output opcode, imm, reg_data, pc,
    input  acc_out, acc_nz, alu_out, alu_op, reg_we, mem_we, lw_sel, acc_we,
           acc_src_imm, mem_addr_acc, branch, branch_taken, alu_src_reg
  );

  modport slave (
    input  opcode, imm, reg_data, pc,
    output acc_out, acc_nz, alu_out, alu_op, reg_we, mem_we, lw_sel, acc_we,
           acc_src_imm, mem_addr_acc, branch, branch_taken, alu_src_reg
  );
endinterface

// File: rtl/acc_alu_core.sv
// Combinational ALU: A op B with modulo-2^DATA_W wrap, plus the pc+1 link value.
module acc_alu_core
  import acc_isa_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic        [DATA_W-1:0] pc,
  input  alu_op_e                  alu_op,
  output logic        [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (alu_op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_NAND: y = ~(a & b);
      ALU_LINK: y = pc + DATA_W'(1);
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/acc_alu_control.sv
// Accumulator-machine control slice: opcode decode, the accumulator register
// and the ALU. Decode has no latency; the accumulator is the only state.
module acc_alu_control
  import acc_isa_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMM_W  = 5
) (
  input logic                clk,
  input logic                rst_n,
  acc_alu_control_if.slave   bus
);

  ctrl_t             ctrl;
  logic [DATA_W-1:0] acc_p0;
  logic [DATA_W-1:0] acc_next;
  logic [DATA_W-1:0] alu_y;

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] v);
    sext_imm = {{(DATA_W-IMM_W){v[IMM_W-1]}}, v};
  endfunction

  always_comb begin
    ctrl = '0;
    case (bus.opcode)
      OP_ADD:  begin ctrl.alu_op = ALU_ADD;  ctrl.reg_we = 1'b1; ctrl.alu_src_reg = 1'b1; end
      OP_SUB:  begin ctrl.alu_op = ALU_SUB;  ctrl.reg_we = 1'b1; ctrl.alu_src_reg = 1'b1; end
      OP_NAND: begin ctrl.alu_op = ALU_NAND; ctrl.reg_we = 1'b1; ctrl.alu_src_reg = 1'b1; end
      OP_LI:   begin ctrl.acc_we = 1'b1; ctrl.acc_src_imm = 1'b1; end
      OP_LA:   begin ctrl.acc_we = 1'b1; end
      OP_LW:   begin ctrl.reg_we = 1'b1; ctrl.lw_sel = 1'b1; ctrl.mem_addr_acc = 1'b1; end
      OP_SW:   begin ctrl.mem_we = 1'b1; ctrl.mem_addr_acc = 1'b1; end
      OP_BNZ:  begin ctrl.branch = 1'b1; end
      default: ctrl = '0;
    endcase
  end

  assign acc_next = ctrl.acc_src_imm ? sext_imm(bus.imm) : bus.reg_data;

  // Stage p0: accumulator register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           acc_p0 <= '0;
    else if (ctrl.acc_we) acc_p0 <= acc_next;
  end

  acc_alu_core #(.DATA_W(DATA_W)) u_alu (
    .a      (acc_p0),
    .b      (bus.reg_data),
    .pc     (bus.pc),
    .alu_op (ctrl.alu_op),
    .y      (alu_y)
  );

  assign bus.acc_out      = acc_p0;
  assign bus.acc_nz       = |acc_p0;
  assign bus.alu_out      = alu_y;
  assign bus.alu_op       = ctrl.alu_op;
  assign bus.reg_we       = ctrl.reg_we;
  assign bus.mem_we       = ctrl.mem_we;
  assign bus.lw_sel       = ctrl.lw_sel;
  assign bus.acc_we       = ctrl.acc_we;
  assign bus.acc_src_imm  = ctrl.acc_src_imm;
  assign bus.mem_addr_acc = ctrl.mem_addr_acc;
  assign bus.branch       = ctrl.branch;
  assign bus.branch_taken = ctrl.branch & (|acc_p0);
  assign bus.alu_src_reg  = ctrl.alu_src_reg;

endmodule

// File: tb/tb_acc_alu_control.sv
// Bench for acc_alu_control: directed scenarios plus randomized instructions
// checked against an instruction-level model of the accumulator machine.
module tb_acc_alu_control;
  localparam int DATA_W = 8;
  localparam int IMM_W  = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  acc_alu_control_if #(.DATA_W(DATA_W), .IMM_W(IMM_W)) bus ();
  acc_alu_control #(.DATA_W(DATA_W), .IMM_W(IMM_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;
  logic [7:0] acc_m;
  logic [9:0] dut_ctrl;

  // {alu_op, reg_we, mem_we, lw_sel, acc_we, acc_src_imm, mem_addr_acc, branch, alu_src_reg}
  assign dut_ctrl = {bus.alu_op, bus.reg_we, bus.mem_we, bus.lw_sel, bus.acc_we,
                     bus.acc_src_imm, bus.mem_addr_acc, bus.branch, bus.alu_src_reg};

  function automatic logic [9:0] exp_ctrl(input logic [2:0] op);
    case (op)
      3'd0:    exp_ctrl = 10'b00_1000_0001;
      3'd1:    exp_ctrl = 10'b01_1000_0001;
      3'd2:    exp_ctrl = 10'b10_1000_0001;
      3'd3:    exp_ctrl = 10'b00_0001_1000;
      3'd4:    exp_ctrl = 10'b00_0001_0000;
      3'd5:    exp_ctrl = 10'b00_1010_0100;
      3'd6:    exp_ctrl = 10'b00_0100_0100;
      default: exp_ctrl = 10'b00_0000_0010;
    endcase
  endfunction

  function automatic logic [7:0] exp_alu(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    int r;
    case (op)
      3'd1:    r = int'(a) - int'(b);
      3'd2:    r = ~(int'(a) & int'(b));
      default: r = int'(a) + int'(b);
    endcase
    exp_alu = r[7:0];
  endfunction

  function automatic logic [7:0] sext5(input logic [4:0] v);
    int s;
    s = (v >= 5'd16) ? int'(v) - 32 : int'(v);
    sext5 = s[7:0];
  endfunction

  task automatic drive(input logic [2:0] op, input logic [4:0] im,
                       input logic [7:0] rd, input logic [7:0] p);
    @(negedge clk);
    bus.opcode = op; bus.imm = im; bus.reg_data = rd; bus.pc = p;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.opcode = 3'd7; bus.imm = '0; bus.reg_data = '0; bus.pc = '0;
    #2;
    checks++; if (bus.acc_out !== 8'h00) $display("FAIL reset_init acc_out=%h expected=00", bus.acc_out); else passes++;
    @(negedge clk) rst_n = 1'b1;
    drive(3'd4, 5'd0, 8'h55, 8'h00);
    tick();
    checks++; if (bus.acc_out !== 8'h55) $display("FAIL load_55 acc_out=%h expected=55", bus.acc_out); else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.acc_out !== 8'h00) $display("FAIL async_reset acc_out=%h expected=00", bus.acc_out); else passes++;
    checks++; if (bus.acc_nz !== 1'b0) $display("FAIL async_reset_nz acc_nz=%b expected=0", bus.acc_nz); else passes++;
    drive(3'd3, 5'd7, 8'h00, 8'h00);
    checks++; if (dut_ctrl !== exp_ctrl(3'd3)) $display("FAIL decode_in_reset ctrl=%b expected=%b", dut_ctrl, exp_ctrl(3'd3)); else passes++;
    tick();
    checks++; if (bus.acc_out !== 8'h00) $display("FAIL we_in_reset acc_out=%h expected=00", bus.acc_out); else passes++;
    drive(3'd7, 5'd0, 8'h00, 8'h00);
    checks++; if (bus.branch_taken !== 1'b0 || bus.branch !== 1'b1)
      $display("FAIL reset_branch branch=%b taken=%b expected=1,0", bus.branch, bus.branch_taken); else passes++;
    rst_n = 1'b1;
    #1;
    checks++; if (bus.acc_out !== 8'h00) $display("FAIL release acc_out=%h expected=00", bus.acc_out); else passes++;
    acc_m = 8'h00;
  endtask

  task automatic test_li();
    drive(3'd3, 5'b10000, 8'($urandom), 8'($urandom));
    tick();
    checks++; if (bus.acc_out !== 8'hF0) $display("FAIL li_neg acc_out=%h expected=f0", bus.acc_out); else passes++;
    drive(3'd3, 5'b00111, 8'($urandom), 8'($urandom));
    tick();
    checks++; if (bus.acc_out !== 8'h07) $display("FAIL li_pos acc_out=%h expected=07", bus.acc_out); else passes++;
    acc_m = 8'h07;
  endtask

  task automatic test_alu();
    logic [7:0] want [3];
    want[0] = 8'h80; want[1] = 8'h7E; want[2] = 8'hFE;
    drive(3'd4, 5'd0, 8'h7F, 8'h00);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(3'(k), 5'($urandom), 8'h01, 8'($urandom));
      checks++; if (bus.alu_out !== want[k] || bus.reg_we !== 1'b1)
        $display("FAIL alu_op%0d alu_out=%h reg_we=%b expected=%h,1", k, bus.alu_out, bus.reg_we, want[k]); else passes++;
    end
    acc_m = 8'h7F;
  endtask

  task automatic test_wrap();
    drive(3'd4, 5'd0, 8'hFF, 8'h00);
    tick();
    drive(3'd0, 5'd1, 8'h01, 8'h00);
    checks++; if (bus.alu_out !== 8'h00) $display("FAIL wrap_add alu_out=%h expected=00", bus.alu_out); else passes++;
    drive(3'd3, 5'd0, 8'h00, 8'h00);
    tick();
    drive(3'd1, 5'd1, 8'h01, 8'h00);
    checks++; if (bus.alu_out !== 8'hFF) $display("FAIL wrap_sub alu_out=%h expected=ff", bus.alu_out); else passes++;
    acc_m = 8'h00;
  endtask

  task automatic test_branch();
    drive(3'd3, 5'd0, 8'h00, 8'h00);
    tick();
    drive(3'd7, 5'd2, 8'h40, 8'h10);
    checks++; if (bus.branch !== 1'b1 || bus.branch_taken !== 1'b0)
      $display("FAIL bnz_zero branch=%b taken=%b expected=1,0", bus.branch, bus.branch_taken); else passes++;
    drive(3'd3, 5'd3, 8'h00, 8'h00);
    tick();
    drive(3'd7, 5'd2, 8'h40, 8'h10);
    checks++; if (bus.branch_taken !== 1'b1 || bus.acc_nz !== 1'b1)
      $display("FAIL bnz_nonzero taken=%b acc_nz=%b expected=1,1", bus.branch_taken, bus.acc_nz); else passes++;
    acc_m = 8'h03;
  endtask

  task automatic test_decode_sweep();
    drive(3'd4, 5'd0, 8'h3C, 8'h00);
    tick();
    drive(3'd5, 5'd9, 8'hA5, 8'h00);
    checks++; if ({bus.reg_we, bus.lw_sel, bus.mem_addr_acc, bus.mem_we} !== 4'b1110)
      $display("FAIL decode_lw got=%b%b%b%b expected=1110", bus.reg_we, bus.lw_sel, bus.mem_addr_acc, bus.mem_we); else passes++;
    tick();
    drive(3'd6, 5'd9, 8'hA5, 8'h00);
    checks++; if ({bus.reg_we, bus.lw_sel, bus.mem_addr_acc, bus.mem_we} !== 4'b0011)
      $display("FAIL decode_sw got=%b%b%b%b expected=0011", bus.reg_we, bus.lw_sel, bus.mem_addr_acc, bus.mem_we); else passes++;
    tick();
    checks++; if (bus.acc_out !== 8'h3C) $display("FAIL lw_sw_hold acc_out=%h expected=3c", bus.acc_out); else passes++;
    acc_m = 8'h3C;
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [4:0] im;
    logic [7:0] rd;
    logic [7:0] p;
    for (int n = 0; n < 300; n++) begin
      op = 3'($urandom); im = 5'($urandom); rd = 8'($urandom); p = 8'($urandom);
      drive(op, im, rd, p);
      checks++; if (dut_ctrl !== exp_ctrl(op))
        $display("FAIL rnd_ctrl n=%0d op=%0d ctrl=%b expected=%b", n, op, dut_ctrl, exp_ctrl(op)); else passes++;
      checks++; if (bus.alu_out !== exp_alu(op, acc_m, rd))
        $display("FAIL rnd_alu n=%0d op=%0d alu_out=%h expected=%h", n, op, bus.alu_out, exp_alu(op, acc_m, rd)); else passes++;
      checks++; if (bus.branch_taken !== ((op == 3'd7) && (acc_m != 8'h00)) || bus.acc_nz !== (acc_m != 8'h00))
        $display("FAIL rnd_flags n=%0d taken=%b nz=%b acc_model=%h", n, bus.branch_taken, bus.acc_nz, acc_m); else passes++;
      tick();
      if (op == 3'd3) acc_m = sext5(im);
      else if (op == 3'd4) acc_m = rd;
      checks++; if (bus.acc_out !== acc_m)
        $display("FAIL rnd_acc n=%0d op=%0d acc_out=%h expected=%h", n, op, bus.acc_out, acc_m); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_li();
    test_alu();
    test_wrap();
    test_branch();
    test_decode_sweep();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/acc_alu_control.md
ACC_ALU_CONTROL -- requirements
Module: acc_alu_control

Interface
REQ-001 SHALL have parameter DATA_W, default 8, datapath/accumulator width.
REQ-002 SHALL have parameter IMM_W, default 5, immediate field width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port opcode  input  3  instruction bits [7:5].
REQ-006 SHALL have port imm  input  IMM_W  instruction bits [4:0].
REQ-007 SHALL have port reg_data  input  DATA_W  register-file read data R[imm].
REQ-008 SHALL have port pc  input  DATA_W  current program counter.
REQ-009 SHALL have port acc_out  output  DATA_W  accumulator contents.
REQ-010 SHALL have port acc_nz  output  1  high when acc_out != 0.
REQ-011 SHALL have port alu_out  output  DATA_W  ALU result.
REQ-012 SHALL have port alu_op  output  2  decoded ALU function.
REQ-013 SHALL have ports reg_we, mem_we, lw_sel, acc_we, acc_src_imm, mem_addr_acc, branch, branch_taken, alu_src_reg  output  1 each  decoded controls.

Function
REQ-014 Decode SHALL be purely combinational from opcode; no decode latency.
REQ-015 Opcode 000 ADD SHALL drive alu_op=00, reg_we=1, alu_src_reg=1: R[imm] <= ACC + R[imm].
REQ-016 Opcode 001 SUB SHALL drive alu_op=01, reg_we=1, alu_src_reg=1: R[imm] <= ACC - R[imm].
REQ-017 Opcode 010 NAND SHALL drive alu_op=10, reg_we=1, alu_src_reg=1: R[imm] <= ~(ACC & R[imm]).
REQ-018 Opcode 011 LI SHALL drive acc_we=1, acc_src_imm=1: ACC <= sign-extended imm.
REQ-019 Opcode 100 LA SHALL drive acc_we=1, acc_src_imm=0: ACC <= reg_data.
REQ-020 Opcode 101 LW SHALL drive reg_we=1, lw_sel=1, mem_addr_acc=1: R[imm] <= MEM[ACC].
REQ-021 Opcode 110 SW SHALL drive mem_we=1, mem_addr_acc=1: MEM[ACC] <= R[imm].
REQ-022 Opcode 111 BNZ SHALL drive branch=1: PC <= R[imm] when ACC != 0.
REQ-023 Every control output not listed for an opcode SHALL be 0; alu_op SHALL be 00 for non-ALU opcodes.
REQ-024 ALU SHALL be combinational with A=acc_out, B=reg_data: 00 A+B, 01 A-B, 10 ~(A&B), 11 pc+1 (link value, not issued by decoder).
REQ-025 Arithmetic SHALL wrap modulo 2^DATA_W; no carry/overflow outputs.
REQ-026 Sign extension SHALL replicate imm[IMM_W-1] into upper bits (imm 5'b10000 -> 8'hF0).
REQ-027 Accumulator SHALL load the selected source on rising clk when acc_we=1, else hold.
REQ-028 acc_nz SHALL be OR-reduction of acc_out, combinational.
REQ-029 branch_taken SHALL equal branch AND acc_nz, combinational.
REQ-030 alu_out SHALL track operand changes in the same cycle, including after an accumulator update.
REQ-031 Unknown/X opcode inputs need not be handled; all 8 encodings are defined.

Reset
REQ-032 While rst_n=0, acc_out SHALL be 0 immediately, independent of clk; acc_nz and branch_taken therefore 0.
REQ-033 Deassertion of rst_n SHALL take effect with the next rising clk; an acc_we coinciding with active reset SHALL be ignored.
REQ-034 Decoded controls SHALL remain combinational functions of opcode during reset.

Structure
REQ-035 Opcode encodings (3-bit) and alu_op encodings (2-bit) SHALL be constants in a shared package acc_isa_pkg.
REQ-036 The ALU SHALL be one sub-module, acc_alu_core; decode and accumulator SHALL be inline.
REQ-037 The block SHALL contain exactly one state element: the DATA_W-bit accumulator.

Verification
REQ-038 Reset: rst_n=0 mid-cycle after ACC=8'h55 -> acc_out=0, acc_nz=0 without a clock edge.
REQ-039 LI: opcode=011, imm=5'b10000 then imm=5'b00111 on two edges -> ACC=8'hF0 then 8'h07.
REQ-040 ALU: ACC=8'h7F, reg_data=8'h01, opcode 000/001/010 -> alu_out=8'h80/8'h7E/8'hFE, reg_we=1.
REQ-041 Wrap: ACC=8'hFF, reg_data=8'h01, ADD -> alu_out=8'h00; ACC=8'h00, SUB -> 8'hFF.
REQ-042 Branch: opcode=111 with ACC=0 -> branch=1, branch_taken=0; ACC=8'h03 -> branch_taken=1.
REQ-043 Decode sweep: opcodes 101 and 110 -> (reg_we,lw_sel,mem_addr_acc,mem_we) = 1,1,1,0 and 0,0,1,1; ACC unchanged.
